axis_pkt_arbiter: RTL

- Packet-level round-robin arbiter that merges C_NUM_SLAVES AXI4-Stream sources (typically net2axis generators) into one AXI4-Stream master.
- Grant is locked from the first beat of a packet until its TLAST handshake, so packets are never interleaved.
- Aggregates per-source DONE into one DONE for the testbench top level.
- Sits between the traffic generators and the DUT input.

---
 rtl/axis_pkt_arbiter_pkg.sv | 27 ++
 rtl/axis_rr_pick.sv | 33 +++
 rtl/axis_pkt_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/axis_pkt_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_pkt_arbiter_pkg : state encoding and width helpers for the packet arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package axis_pkt_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int grant_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_rr_pick : first requester at or after base, searching modulo N
// Rev 1.0
// ----------------------------------------------------------------------------
module axis_rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] base,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W-1:0] cand;

  // Walk from the farthest offset back to base so the nearest requester wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = W'((int'(base) + k) % N);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_pkt_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_pkt_arbiter : packet-locked round-robin merge of AXI4-Stream sources
// Rev 1.0
// ----------------------------------------------------------------------------
module axis_pkt_arbiter
  import axis_pkt_arbiter_pkg::*;
#(
  parameter int C_NUM_SLAVES  = 2,
  parameter int C_TDATA_WIDTH = 32,
  parameter int C_CNT_WIDTH   = 16
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic [C_NUM_SLAVES-1:0]                S_AXIS_TVALID,
  input  logic [C_NUM_SLAVES*C_TDATA_WIDTH-1:0]  S_AXIS_TDATA,
  input  logic [C_NUM_SLAVES*C_TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
  input  logic [C_NUM_SLAVES-1:0]                S_AXIS_TLAST,
  output logic [C_NUM_SLAVES-1:0]                S_AXIS_TREADY,
  input  logic [C_NUM_SLAVES-1:0]                S_DONE,
  output logic                                   M_AXIS_TVALID,
  output logic [C_TDATA_WIDTH-1:0]               M_AXIS_TDATA,
  output logic [C_TDATA_WIDTH/8-1:0]             M_AXIS_TKEEP,
  output logic                                   M_AXIS_TLAST,
  input  logic                                   M_AXIS_TREADY,
  output logic [grant_width(C_NUM_SLAVES)-1:0]   GRANT,
  output logic [C_CNT_WIDTH-1:0]                 PKT_CNT,
  output logic                                   DONE
);

  localparam int KW = C_TDATA_WIDTH / 8;
  localparam int GW = grant_width(C_NUM_SLAVES);
  localparam logic [GW-1:0] LAST_IDX = GW'(C_NUM_SLAVES - 1);

  state_t        state, state_nxt;
  logic [GW-1:0] last_grant, grant_nxt;
  logic [GW-1:0] pick_base, pick_idx;
  logic          pick_found;
  logic          eop;

  // One picker serves both searches: from last_grant+1 when idle, GRANT+1 at end of packet.
  assign pick_base = (state == XFER) ? (GRANT + GW'(1)) : (last_grant + GW'(1));

  axis_rr_pick #(
    .N (C_NUM_SLAVES),
    .W (GW)
  ) u_pick (
    .req   (S_AXIS_TVALID),
    .base  (pick_base),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_nxt     = state;
    grant_nxt     = GRANT;
    eop           = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TKEEP  = '0;
    M_AXIS_TLAST  = 1'b0;
    S_AXIS_TREADY = '0;
    if (ARESETN) begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_nxt = pick_idx;
            state_nxt = XFER;
          end
        end
        XFER: begin
          M_AXIS_TVALID        = S_AXIS_TVALID[GRANT];
          M_AXIS_TDATA         = S_AXIS_TDATA[GRANT*C_TDATA_WIDTH +: C_TDATA_WIDTH];
          M_AXIS_TKEEP         = S_AXIS_TKEEP[GRANT*KW +: KW];
          M_AXIS_TLAST         = S_AXIS_TLAST[GRANT];
          S_AXIS_TREADY[GRANT] = M_AXIS_TREADY;
          eop = M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST;
          if (eop) begin
            if (pick_found) grant_nxt = pick_idx;
            else            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state      <= IDLE;
      GRANT      <= '0;
      last_grant <= LAST_IDX;
      PKT_CNT    <= '0;
      DONE       <= 1'b0;
    end else begin
      state <= state_nxt;
      GRANT <= grant_nxt;
      DONE  <= (&S_DONE) && (state == IDLE) && !(|S_AXIS_TVALID);
      if (eop) begin
        PKT_CNT    <= PKT_CNT + C_CNT_WIDTH'(1);
        last_grant <= GRANT;
      end
    end
  end

endmodule
`default_nettype wire
